// File: rtl/mod_addsub_pipe.sv
// Two-stage, multi-lane modular add/subtract pipeline with valid/ready on both sides.
// Optional input range flags enabled by defining MOD_ADDSUB_RANGE_CHECK_EN.
module mod_addsub_pipe #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned Q     = 3329,
    parameter int unsigned LANES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   in_mode_i,
    input  logic [LANES*WIDTH-1:0] in_op1_i,
    input  logic [LANES*WIDTH-1:0] in_op2_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    output logic [LANES-1:0]       out_range_err_o,
`endif
    output logic [LANES*WIDTH-1:0] out_result_o
);

    localparam logic [WIDTH:0] Q_EXT = (WIDTH+1)'(Q);

    logic                        s1_valid;
    logic                        s1_mode;
    logic [LANES-1:0][WIDTH:0]   s1_raw;
    logic [LANES-1:0][WIDTH-1:0] s1_corr;
    logic [LANES-1:0][WIDTH:0]   raw_d;
    logic [LANES-1:0][WIDTH:0]   corr_full;
    logic [LANES-1:0][WIDTH-1:0] corr_d;
    logic [LANES*WIDTH-1:0]      result_d;
    logic                        stage2_ready;
    logic                        stage1_ready;

    assign stage2_ready = !out_valid_o || out_ready_i;
    assign stage1_ready = !s1_valid || stage2_ready;
    assign in_ready_o   = stage1_ready;

    // Only the low WIDTH bits of c are ever selected, so c is stored pre-truncated.
    always_comb begin
        raw_d     = '0;
        corr_full = '0;
        corr_d    = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (in_mode_i) begin
                raw_d[k]     = {1'b0, in_op1_i[k*WIDTH +: WIDTH]} - {1'b0, in_op2_i[k*WIDTH +: WIDTH]};
                corr_full[k] = raw_d[k] + Q_EXT;
            end else begin
                raw_d[k]     = {1'b0, in_op1_i[k*WIDTH +: WIDTH]} + {1'b0, in_op2_i[k*WIDTH +: WIDTH]};
                corr_full[k] = raw_d[k] - Q_EXT;
            end
            corr_d[k] = corr_full[k][WIDTH-1:0];
        end
    end

    always_comb begin
        result_d = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (s1_mode ? s1_raw[k][WIDTH] : (s1_raw[k] >= Q_EXT))
                result_d[k*WIDTH +: WIDTH] = s1_corr[k];
            else
                result_d[k*WIDTH +: WIDTH] = s1_raw[k][WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_raw   <= '0;
            s1_corr  <= '0;
        end else if (stage1_ready) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_mode <= in_mode_i;
                s1_raw  <= raw_d;
                s1_corr <= corr_d;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o  <= 1'b0;
            out_result_o <= '0;
        end else if (stage2_ready) begin
            out_valid_o <= s1_valid;
            if (s1_valid)
                out_result_o <= result_d;
        end
    end

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    logic [LANES-1:0] err_d;
    logic [LANES-1:0] s1_err;

    always_comb begin
        err_d = '0;
        for (int unsigned k = 0; k < LANES; k++)
            err_d[k] = ({1'b0, in_op1_i[k*WIDTH +: WIDTH]} >= Q_EXT) ||
                       ({1'b0, in_op2_i[k*WIDTH +: WIDTH]} >= Q_EXT);
    end

    // Flags follow the same enables as the data so they stay aligned with their beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_err          <= '0;
            out_range_err_o <= '0;
        end else begin
            if (stage1_ready && in_valid_i)
                s1_err <= err_d;
            if (stage2_ready && s1_valid)
                out_range_err_o <= s1_err;
        end
    end
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed self-checking bench for mod_addsub_pipe (WIDTH=12, Q=3329, LANES=4).
// Range-flag checks are compiled in when MOD_ADDSUB_RANGE_CHECK_EN is defined.
module tb_mod_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [47:0] in_op1;
    logic [47:0] in_op2;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_result;
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    logic [3:0]  out_err;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    logic [47:0] bp_a [5];
    logic [47:0] bp_b [5];
    logic [47:0] bp_e [5];
    logic        bp_m [5];

    always #5 clk = ~clk;

    mod_addsub_pipe #(.WIDTH(12), .Q(3329), .LANES(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_mode_i    (in_mode),
        .in_op1_i     (in_op1),
        .in_op2_i     (in_op2),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
        .out_range_err_o (out_err),
`endif
        .out_result_o (out_result)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // One isolated beat with out_ready high: result visible after the second edge.
    task automatic single_beat(input string tag, input logic mode, input logic [47:0] a,
                               input logic [47:0] b, input logic [47:0] exp,
                               input logic chk_res, input logic [3:0] exp_err);
        @(negedge clk);
        chk({tag, "_in_ready"}, {47'd0, in_ready}, 48'd1);
        in_valid = 1'b1;
        in_mode  = mode;
        in_op1   = a;
        in_op2   = b;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, {47'd0, out_valid}, 48'd0);
        @(negedge clk);
        chk({tag, "_lat2_valid"}, {47'd0, out_valid}, 48'd1);
        if (chk_res)
            chk({tag, "_result"}, out_result, exp);
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
        chk({tag, "_range_err"}, {44'd0, out_err}, {44'd0, exp_err});
`else
        if (exp_err != 4'd0)
            chk({tag, "_exp_err_unused"}, {44'd0, exp_err}, 48'd0);
`endif
        @(negedge clk);
        chk({tag, "_drained"}, {47'd0, out_valid}, 48'd0);
    endtask

    initial begin
        int tx;
        int rx;

        bp_m[0] = 1'b0; bp_a[0] = {12'd3328, 12'd1,    12'd3000, 12'd100};
        bp_b[0] = {12'd0,    12'd2,    12'd500,  12'd200};  bp_e[0] = {12'd3328, 12'd3,  12'd171,  12'd300};
        bp_m[1] = 1'b1; bp_a[1] = {12'd3328, 12'd7,    12'd500,  12'd100};
        bp_b[1] = {12'd1,    12'd7,    12'd3000, 12'd200};  bp_e[1] = {12'd3327, 12'd0,  12'd829,  12'd3229};
        bp_m[2] = 1'b0; bp_a[2] = {12'd1700, 12'd11,   12'd2000, 12'd2000};
        bp_b[2] = {12'd1700, 12'd22,   12'd1328, 12'd1329}; bp_e[2] = {12'd71,   12'd33, 12'd3328, 12'd0};
        bp_m[3] = 1'b1; bp_a[3] = {12'd0,    12'd3328, 12'd2,    12'd1};
        bp_b[3] = {12'd1,    12'd3328, 12'd1,    12'd2};    bp_e[3] = {12'd3328, 12'd0,  12'd1,    12'd3328};
        bp_m[4] = 1'b0; bp_a[4] = {12'd1665, 12'd5,    12'd3328, 12'd1234};
        bp_b[4] = {12'd1664, 12'd5,    12'd3328, 12'd2000}; bp_e[4] = {12'd0,    12'd10, 12'd3327, 12'd3234};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_op1    = '0;
        in_op2    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", {47'd0, out_valid}, 48'd0);
        chk("reset_result", out_result, 48'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", {47'd0, in_ready}, 48'd1);

        single_beat("sub_under", 1'b1, {12'd0, 12'd0, 12'd10, 12'd5},
                    {12'd3328, 12'd0, 12'd5, 12'd10}, {12'd1, 12'd0, 12'd5, 12'd3324}, 1'b1, 4'b0000);
        single_beat("add_wrap", 1'b0, {12'd3328, 12'd1664, 12'd3000, 12'd3328},
                    {12'd3328, 12'd1664, 12'd1000, 12'd1}, {12'd3327, 12'd3328, 12'd671, 12'd0}, 1'b1, 4'b0000);
        single_beat("add_zero", 1'b0, 48'd0, 48'd0, 48'd0, 1'b1, 4'b0000);
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
        single_beat("range_l3", 1'b0, {12'd3329, 12'd1, 12'd2, 12'd3},
                    {12'd0, 12'd1, 12'd2, 12'd3}, 48'd0, 1'b0, 4'b1000);
`endif

        // Five back-to-back beats, downstream stalled on loop cycles 2..5.
        tx = 0;
        rx = 0;
        for (int c = 0; c < 40 && rx < 5; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 5);
            #1;
            if (c == 2)
                chk("bp_accepted_before_full", tx, 2);
            if (c >= 2 && c <= 5) begin
                chk("bp_in_ready_low", {47'd0, in_ready}, 48'd0);
                chk("bp_hold_valid", {47'd0, out_valid}, 48'd1);
                chk("bp_hold_result", out_result, bp_e[0]);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_result%0d", rx), out_result, bp_e[rx]);
                rx++;
            end
            if (tx < 5) begin
                in_valid = 1'b1;
                in_mode  = bp_m[tx];
                in_op1   = bp_a[tx];
                in_op2   = bp_b[tx];
                if (in_ready)
                    tx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("bp_rx_count", rx, 5);
        repeat (2) @(negedge clk);
        chk("bp_no_dup", {47'd0, out_valid}, 48'd0);

        // Two beats in flight, then asynchronous reset between edges.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_mode  = bp_m[i];
            in_op1   = bp_a[i];
            in_op2   = bp_b[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_pre_valid", {47'd0, out_valid}, 48'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {47'd0, out_valid}, 48'd0);
        chk("rst_async_result", out_result, 48'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_stale", {47'd0, out_valid}, 48'd0);
        end
        single_beat("post_rst_sub", 1'b1, {12'd0, 12'd0, 12'd0, 12'd7},
                    {12'd0, 12'd0, 12'd0, 12'd9}, {12'd0, 12'd0, 12'd0, 12'd3327}, 1'b1, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
